// File: rtl/wavetable_osc_reader.sv
// rtl/wavetable_osc_reader.sv - phase-accumulating wavetable reader with linear interpolation
//
// Purpose: on each accepted sample tick, reads two adjacent entries of a
// 512x16 registered-output wavetable RAM and emits one linearly
// interpolated 16-bit offset-binary sample.
//
// Ports:
//   clk          system clock, shared with the RAM
//   rst          asynchronous active-high reset
//   tick         one-cycle sample strobe
//   tune_word    phase increment, applied when a tick is accepted
//   phase_sync   hard-sync: phase returns to 0 on the next edge
//   ram_addr     registered RAM address
//   ram_re       registered RAM read enable
//   ram_ce       registered RAM chip enable
//   ram_rdata    RAM read data (valid the edge after re=ce=1 was sampled)
//   sample_out   interpolated sample, held between updates
//   sample_valid one-cycle pulse when sample_out updates
//   busy         high while a read/interpolate sequence is in flight
//   overrun      sticky flag, set when a tick arrives while busy

module wavetable_osc_reader #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [PHASE_W-1:0] tune_word,
    input  logic               phase_sync,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_re,
    output logic               ram_ce,
    input  logic [15:0]        ram_rdata,
    output logic [15:0]        sample_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        HOLD0,
        RD1,
        HOLD1,
        CALC
    } state_t;

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic [7:0]         frac;
    logic [15:0]        s0;
    logic [15:0]        s1;

    logic               tick_accept;
    logic signed [16:0] diff;
    logic signed [25:0] prod;
    logic [15:0]        interp;

    assign tick_accept = tick && (state == IDLE);

    // The arithmetic shift floors toward -inf, which keeps the result
    // between s0 and s1 for every frac, so no clamping is needed.
    always_comb begin
        diff   = $signed({1'b0, s1}) - $signed({1'b0, s0});
        prod   = 26'(diff) * 26'($signed({1'b0, frac}));
        interp = 16'($signed({10'b0, s0}) + (prod >>> 8));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            frac         <= '0;
            s0           <= '0;
            s1           <= '0;
            ram_addr     <= '0;
            ram_re       <= 1'b0;
            ram_ce       <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;

            // Sync wins over the increment; a tick accepted in the same
            // cycle still reads from the pre-sync phase latched below.
            if (phase_sync) begin
                phase <= '0;
            end else if (tick_accept) begin
                phase <= phase + tune_word;
            end

            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            // ram_addr is held through each HOLD state because the RAM's
            // bank mux looks at the live address bit 8 when data returns.
            case (state)
                IDLE: begin
                    if (tick) begin
                        ram_addr <= phase[PHASE_W-1 -: ADDR_W];
                        frac     <= phase[PHASE_W-ADDR_W-1 -: 8];
                        ram_re   <= 1'b1;
                        ram_ce   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= RD0;
                    end
                end
                RD0: begin
                    ram_re <= 1'b0;
                    ram_ce <= 1'b0;
                    state  <= HOLD0;
                end
                HOLD0: begin
                    s0       <= ram_rdata;
                    ram_addr <= ram_addr + ADDR_W'(1);
                    ram_re   <= 1'b1;
                    ram_ce   <= 1'b1;
                    state    <= RD1;
                end
                RD1: begin
                    ram_re <= 1'b0;
                    ram_ce <= 1'b0;
                    state  <= HOLD1;
                end
                HOLD1: begin
                    s1    <= ram_rdata;
                    state <= CALC;
                end
                CALC: begin
                    sample_out   <= interp;
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
